// File: rtl/lfsr_seq_checker_if.sv
// Stream-side bundle of the LFSR sequence checker: sampled bit stream in, lock/error status out.
// master = stream source / status consumer, slave = the checker itself.
interface lfsr_seq_checker_if #(
    parameter int ERR_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             clear_cnt;
    logic             locked;
    logic             bit_err;
    logic [ERR_W-1:0] err_count;
    logic             lockup;
    logic             resync;

    modport master (
        output in_valid, in_bit, clear_cnt,
        input  locked, bit_err, err_count, lockup, resync
    );

    modport slave (
        input  in_valid, in_bit, clear_cnt,
        output locked, bit_err, err_count, lockup, resync
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 10-bit XNOR LFSR stream (x[n+10] = ~(x[n+3]^x[n])).
// Latency: every status output reflects the sampled bit one cycle later.
// Backpressure: none; a bit is consumed on every in_valid cycle and idle cycles change nothing.
module lfsr_seq_checker #(
    parameter int LOCK_CNT  = 32,
    parameter int ERR_LIMIT = 4,
    parameter int WINDOW    = 64,
    parameter int ERR_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    lfsr_seq_checker_if.slave    bus
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LIM    = EW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } state_t;

    state_t           state;
    logic [9:0]       hist;
    logic [3:0]       fill_cnt;
    logic [MW-1:0]    match_cnt;
    logic [WW-1:0]    win_cnt;
    logic [EW-1:0]    win_err;

    logic             locked_q;
    logic             bit_err_q;
    logic [ERR_W-1:0] err_q;
    logic             lockup_q;
    logic             resync_q;

    logic [9:0]       hist_nxt;
    logic             exp_bit;
    logic             mism;
    logic [EW-1:0]    win_err_nxt;
    logic             win_wrap;

    // hist[0] is the oldest bit, so hist[0]/hist[3] are x[n]/x[n+3] for incoming x[n+10]
    assign hist_nxt    = {bus.in_bit, hist[9:1]};
    assign exp_bit     = ~(hist[3] ^ hist[0]);
    assign mism        = bus.in_valid && (state != SEARCH) && (bus.in_bit != exp_bit);
    assign win_err_nxt = win_err + 1'b1;
    assign win_wrap    = (win_cnt == WIN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
            err_q     <= '0;
            lockup_q  <= 1'b0;
            resync_q  <= 1'b0;
        end else begin
            bit_err_q <= 1'b0;
            resync_q  <= 1'b0;

            // clear has priority over a same-cycle increment
            if (bus.clear_cnt) begin
                err_q <= '0;
            end else if (mism && (state == LOCKED) && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end

            if (bus.in_valid) begin
                // wrong bits are shifted in too, so one flip echoes at +7 and +10
                hist     <= hist_nxt;
                lockup_q <= (hist_nxt == 10'h3FF);

                case (state)
                    SEARCH: begin
                        if (fill_cnt == 4'd9) begin
                            state     <= CHECK;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end

                    CHECK: begin
                        if (mism) begin
                            bit_err_q <= 1'b1;
                            match_cnt <= '0;
                        end else if (hist == 10'h3FF) begin
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == MATCH_LAST) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                                win_cnt  <= '0;
                                win_err  <= '0;
                            end
                        end
                    end

                    LOCKED: begin
                        win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
                        if (mism) begin
                            bit_err_q <= 1'b1;
                            if (win_err_nxt >= ERR_LIM) begin
                                state    <= SEARCH;
                                locked_q <= 1'b0;
                                fill_cnt <= '0;
                                resync_q <= 1'b1;
                            end else if (win_wrap) begin
                                win_err <= '0;
                            end else begin
                                win_err <= win_err_nxt;
                            end
                        end else if (win_wrap) begin
                            win_err <= '0;
                        end
                    end

                    default: begin
                        state    <= SEARCH;
                        locked_q <= 1'b0;
                        fill_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.bit_err   = bit_err_q;
    assign bus.err_count = err_q;
    assign bus.lockup    = lockup_q;
    assign bus.resync    = resync_q;

endmodule
